// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one 64-bit memory port between an instruction-fetch requester and a
//   data requester. Data accesses normally win a simultaneous request, but a
//   saturating starvation counter forces a fetch grant after STARVE_LIMIT
//   consecutive data grants made while a fetch was pending.
//
// Ports
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   if_req_i, if_addr_i   : fetch request and 4-byte aligned byte address
//   if_ready_o, if_rdata_o: fetch completion pulse and 32-bit instruction word
//   if_stall_o            : fetch-stage stall, if_req_i & ~if_ready_o
//   d_req_i, d_we_i       : data request and write enable
//   d_addr_i, d_wdata_i   : data byte address and write data
//   d_wstrb_i             : data byte enables
//   d_ready_o, d_rdata_o  : data completion pulse and 64-bit read data
//   mem_req_o, mem_we_o   : shared memory request and write enable
//   mem_addr_o            : 8-byte aligned memory address
//   mem_wdata_o, mem_wstrb_o : memory write data and byte enables
//   mem_ready_i, mem_rdata_i : memory completion pulse and read data
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req_i,
   input  logic [63:0] if_addr_i,
   output logic        if_ready_o,
   output logic [31:0] if_rdata_o,
   output logic        if_stall_o,
   input  logic        d_req_i,
   input  logic        d_we_i,
   input  logic [63:0] d_addr_i,
   input  logic [63:0] d_wdata_i,
   input  logic [7:0]  d_wstrb_i,
   output logic        d_ready_o,
   output logic [63:0] d_rdata_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [63:0] mem_addr_o,
   output logic [63:0] mem_wdata_o,
   output logic [7:0]  mem_wstrb_o,
   input  logic        mem_ready_i,
   input  logic [63:0] mem_rdata_i
);

   localparam logic [2:0] STARVE_LIMIT_C = 3'(STARVE_LIMIT);
   localparam logic [2:0] STARVE_MAX_C   = 3'd7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t      state_q;
   logic [2:0]  starve_cnt_q;
   logic [2:0]  starve_cnt_d;
   logic        mem_req_q;
   logic        mem_we_q;
   logic [63:0] mem_addr_q;
   logic [63:0] mem_wdata_q;
   logic [7:0]  mem_wstrb_q;
   logic        word_sel_q;

   logic        grant_i_s;
   logic        grant_d_s;

   // Low address bits are dropped by the 8-byte alignment of the memory port.
   logic        unused_addr_bits_s;
   assign unused_addr_bits_s = ^{if_addr_i[1:0], d_addr_i[2:0]};

   // Grant decision in IDLE from the current-cycle requests.
   always_comb begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
      if (state_q == IDLE) begin
         if (d_req_i && if_req_i) begin
            // Fetch wins only once the data side has used up its allowance.
            if (starve_cnt_q >= STARVE_LIMIT_C) begin
               grant_i_s = 1'b1;
            end else begin
               grant_d_s = 1'b1;
            end
         end else if (d_req_i) begin
            grant_d_s = 1'b1;
         end else if (if_req_i) begin
            grant_i_s = 1'b1;
         end else begin
            grant_i_s = 1'b0;
            grant_d_s = 1'b0;
         end
      end else begin
         grant_i_s = 1'b0;
         grant_d_s = 1'b0;
      end
   end

   // Starvation counter next value for a data grant.
   always_comb begin
      starve_cnt_d = 3'd0;
      if (if_req_i) begin
         if (starve_cnt_q == STARVE_MAX_C) begin
            starve_cnt_d = STARVE_MAX_C;
         end else begin
            starve_cnt_d = starve_cnt_q + 3'd1;
         end
      end else begin
         starve_cnt_d = 3'd0;
      end
   end

   // Arbiter FSM with the registered memory-side payload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         starve_cnt_q <= 3'd0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 64'd0;
         mem_wdata_q  <= 64'd0;
         mem_wstrb_q  <= 8'd0;
         word_sel_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_i_s) begin
                  state_q      <= BUSY_I;
                  starve_cnt_q <= 3'd0;
                  mem_req_q    <= 1'b1;
                  mem_we_q     <= 1'b0;
                  mem_addr_q   <= {if_addr_i[63:3], 3'b000};
                  mem_wdata_q  <= 64'd0;
                  mem_wstrb_q  <= 8'd0;
                  word_sel_q   <= if_addr_i[2];
               end else if (grant_d_s) begin
                  state_q      <= BUSY_D;
                  starve_cnt_q <= starve_cnt_d;
                  mem_req_q    <= 1'b1;
                  mem_we_q     <= d_we_i;
                  mem_addr_q   <= {d_addr_i[63:3], 3'b000};
                  mem_wdata_q  <= d_wdata_i;
                  mem_wstrb_q  <= d_wstrb_i;
                  word_sel_q   <= 1'b0;
               end else begin
                  // A stray mem_ready in IDLE is ignored here.
                  state_q   <= IDLE;
                  mem_req_q <= 1'b0;
               end
            end
            BUSY_I, BUSY_D: begin
               if (mem_ready_i) begin
                  state_q   <= IDLE;
                  mem_req_q <= 1'b0;
               end else begin
                  state_q   <= state_q;
                  mem_req_q <= 1'b1;
               end
            end
            default: begin
               state_q   <= IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_wstrb_o = mem_wstrb_q;

   // Completion pulses follow mem_ready in the same cycle; read data is
   // forced to zero outside its ready pulse so reset leaves it at zero.
   always_comb begin
      if_ready_o = (state_q == BUSY_I) && mem_ready_i;
      d_ready_o  = (state_q == BUSY_D) && mem_ready_i;
      if (if_ready_o) begin
         if (word_sel_q) begin
            if_rdata_o = mem_rdata_i[63:32];
         end else begin
            if_rdata_o = mem_rdata_i[31:0];
         end
      end else begin
         if_rdata_o = 32'd0;
      end
      if (d_ready_o) begin
         d_rdata_o = mem_rdata_i;
      end else begin
         d_rdata_o = 64'd0;
      end
      // Held low while reset is asserted even if the fetch unit requests.
      if_stall_o = rst_n & if_req_i & ~if_ready_o;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. A transaction-level model (owner,
//   captured payload, starvation count) predicts every output each cycle; a
//   few literal expectations pin the model on known scenarios.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req_i = 1'b0;
   logic [63:0] if_addr_i = 64'd0;
   logic        if_ready_o;
   logic [31:0] if_rdata_o;
   logic        if_stall_o;
   logic        d_req_i = 1'b0;
   logic        d_we_i = 1'b0;
   logic [63:0] d_addr_i = 64'd0;
   logic [63:0] d_wdata_i = 64'd0;
   logic [7:0]  d_wstrb_i = 8'd0;
   logic        d_ready_o;
   logic [63:0] d_rdata_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [63:0] mem_addr_o;
   logic [63:0] mem_wdata_o;
   logic [7:0]  mem_wstrb_o;
   logic        mem_ready_i = 1'b0;
   logic [63:0] mem_rdata_i = 64'd0;

   mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i),
      .if_ready_o(if_ready_o), .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
      .d_wdata_i(d_wdata_i), .d_wstrb_i(d_wstrb_i),
      .d_ready_o(d_ready_o), .d_rdata_o(d_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
      .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_owner = 0;      // 0 none, 1 fetch, 2 data
   logic [63:0] m_addr = 64'd0;
   logic        m_we = 1'b0;
   logic [63:0] m_wdata = 64'd0;
   logic [7:0]  m_wstrb = 8'd0;
   logic        m_hi = 1'b0;
   int          m_starve = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner  <= 0;
         m_starve <= 0;
      end else if (m_owner == 0) begin
         if (d_req_i && (!if_req_i || m_starve < LIMIT)) begin
            m_owner  <= 2;
            m_addr   <= d_addr_i & ~64'h7;
            m_we     <= d_we_i;
            m_wdata  <= d_wdata_i;
            m_wstrb  <= d_wstrb_i;
            m_starve <= if_req_i ? ((m_starve + 1 > 7) ? 7 : m_starve + 1) : 0;
         end else if (if_req_i) begin
            m_owner  <= 1;
            m_addr   <= if_addr_i & ~64'h7;
            m_we     <= 1'b0;
            m_wdata  <= 64'd0;
            m_wstrb  <= 8'd0;
            m_hi     <= if_addr_i[2];
            m_starve <= 0;
         end
      end else if (mem_ready_i) begin
         m_owner <= 0;
      end
   end

   // ---------------- compare process ----------------
   logic        e_ifr, e_dr;
   logic [31:0] e_ifd;
   logic [63:0] e_dd;
   logic        prev_req = 1'b0;
   int          dut_if_cnt = 0;
   int          dut_d_cnt = 0;
   int          req_cycles = 0;
   logic [63:0] grant_log[$];
   logic [31:0] last_if_rdata = 32'd0;

   always @(negedge clk) begin
      if (!rst_n) begin
         e_ifr = 1'b0; e_dr = 1'b0; e_ifd = 32'd0; e_dd = 64'd0;
         check("rst_mem_req", {63'd0, mem_req_o}, 64'd0);
         check("rst_mem_addr", mem_addr_o, 64'd0);
      end else begin
         e_ifr = (m_owner == 1) && mem_ready_i;
         e_dr  = (m_owner == 2) && mem_ready_i;
         e_ifd = e_ifr ? (m_hi ? mem_rdata_i[63:32] : mem_rdata_i[31:0]) : 32'd0;
         e_dd  = e_dr ? mem_rdata_i : 64'd0;
         check("mem_req", {63'd0, mem_req_o}, {63'd0, m_owner != 0});
         if (m_owner != 0) begin
            check("mem_addr", mem_addr_o, m_addr);
            check("mem_we", {63'd0, mem_we_o}, {63'd0, m_we});
            check("mem_wdata", mem_wdata_o, m_wdata);
            check("mem_wstrb", {56'd0, mem_wstrb_o}, {56'd0, m_wstrb});
         end
      end
      check("if_ready", {63'd0, if_ready_o}, {63'd0, e_ifr});
      check("d_ready", {63'd0, d_ready_o}, {63'd0, e_dr});
      check("if_rdata", {32'd0, if_rdata_o}, {32'd0, e_ifd});
      check("d_rdata", d_rdata_o, e_dd);
      check("if_stall", {63'd0, if_stall_o}, {63'd0, rst_n & if_req_i & ~e_ifr});
      if (mem_req_o && !prev_req) grant_log.push_back(mem_addr_o);
      prev_req = mem_req_o;
      if (mem_req_o) req_cycles++;
      if (if_ready_o) begin dut_if_cnt++; last_if_rdata = if_rdata_o; end
      if (d_ready_o) dut_d_cnt++;
   end

   // ---------------- stimulus ----------------
   logic resp_en = 1'b0;
   int   lat = 1;
   int   wait_cnt = 0;

   task automatic tick();
      @(posedge clk); #1;
      if (resp_en) begin
         if (mem_req_o) begin
            mem_ready_i = (wait_cnt == lat - 1);
            wait_cnt++;
         end else begin
            mem_ready_i = 1'b0;
            wait_cnt = 0;
         end
      end
   endtask

   task automatic run_until(input int tgt_if, input int tgt_d, input string name);
      int n = 0;
      while ((dut_if_cnt < tgt_if || dut_d_cnt < tgt_d) && n < 200) begin
         tick();
         n++;
      end
      check({name, "_timeout"}, {63'd0, n >= 200}, 64'd0);
   endtask

   int base_if, base_d, base_log;
   logic [63:0] exp_seq [10];

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      mem_rdata_i = 64'hAAAA_BBBB_CCCC_DDDD;
      tick(); tick();
      check("reset_mem_req", {63'd0, mem_req_o}, 64'd0);
      check("reset_ready", {62'd0, if_ready_o, d_ready_o}, 64'd0);
      rst_n = 1'b1;
      tick();

      // Fetch only, upper word selected.
      resp_en = 1'b1; lat = 1;
      base_log = grant_log.size();
      if_req_i = 1'b1; if_addr_i = 64'h1004;
      run_until(1, 0, "fetch_only");
      if_req_i = 1'b0;
      tick();
      check("fetch_addr", grant_log[base_log], 64'h1000);
      check("fetch_rdata", {32'd0, last_if_rdata}, 64'hAAAA_BBBB);
      check("fetch_pulses", 64'(dut_if_cnt), 64'd1);

      // Data write.
      base_log = grant_log.size();
      d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 64'h2008;
      d_wdata_i = 64'h55; d_wstrb_i = 8'h01;
      tick();
      tick();
      check("dwr_we", {63'd0, mem_we_o}, 64'd1);
      check("dwr_wstrb", {56'd0, mem_wstrb_o}, 64'h01);
      run_until(1, 1, "data_write");
      d_req_i = 1'b0; d_we_i = 1'b0;
      tick();
      check("dwr_addr", grant_log[base_log], 64'h2008);
      check("dwr_pulses", 64'(dut_d_cnt), 64'd1);
      check("dwr_no_fetch", 64'(dut_if_cnt), 64'd1);

      // Simultaneous requests: data first, then fetch (low word).
      base_log = grant_log.size();
      if_req_i = 1'b1; if_addr_i = 64'h3000;
      d_req_i = 1'b1; d_addr_i = 64'h4010; d_wdata_i = 64'd0; d_wstrb_i = 8'd0;
      run_until(1, 2, "both_data");
      d_req_i = 1'b0;
      check("both_stall", {63'd0, if_stall_o}, 64'd1);
      run_until(2, 2, "both_fetch");
      if_req_i = 1'b0;
      tick();
      check("both_first", grant_log[base_log], 64'h4010);
      check("both_second", grant_log[base_log + 1], 64'h3000);
      check("both_low_word", {32'd0, last_if_rdata}, 64'hCCCC_DDDD);

      // Starvation: two rounds of four data grants then one fetch.
      base_log = grant_log.size();
      base_d = dut_d_cnt;
      if_req_i = 1'b1; if_addr_i = 64'h5000;
      d_req_i = 1'b1; d_addr_i = 64'h6000;
      run_until(3, 0, "starve_r1");
      check("model_starve_clr", 64'(m_starve), 64'd0);
      if_addr_i = 64'h5004;
      run_until(4, 0, "starve_r2");
      if_req_i = 1'b0; d_req_i = 1'b0;
      tick();
      exp_seq = '{64'h6000, 64'h6000, 64'h6000, 64'h6000, 64'h5000,
                  64'h6000, 64'h6000, 64'h6000, 64'h6000, 64'h5000};
      check("starve_log_len", 64'(grant_log.size() - base_log), 64'd10);
      for (int i = 0; i < 10; i++) begin
         if (base_log + i < grant_log.size())
            check($sformatf("starve_seq%0d", i), grant_log[base_log + i], exp_seq[i]);
      end
      check("starve_dpulses", 64'(dut_d_cnt - base_d), 64'd8);

      // Five-cycle memory wait; the data request drops while busy.
      lat = 5;
      base_d = dut_d_cnt;
      req_cycles = 0;
      d_req_i = 1'b1; d_addr_i = 64'h7000; d_we_i = 1'b0;
      tick();
      d_req_i = 1'b0;
      run_until(4, base_d + 1, "wait5");
      tick();
      check("wait5_req_cycles", 64'(req_cycles), 64'd5);
      check("wait5_pulses", 64'(dut_d_cnt - base_d), 64'd1);

      // mem_ready while idle is ignored.
      resp_en = 1'b0;
      base_if = dut_if_cnt; base_d = dut_d_cnt;
      mem_ready_i = 1'b1;
      tick(); tick();
      mem_ready_i = 1'b0;
      tick();
      check("idle_rdy_if", 64'(dut_if_cnt - base_if), 64'd0);
      check("idle_rdy_d", 64'(dut_d_cnt - base_d), 64'd0);

      // Reset in the middle of a data transaction.
      base_d = dut_d_cnt;
      d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 64'h8000;
      d_wdata_i = 64'hDEAD_BEEF; d_wstrb_i = 8'hFF;
      if_req_i = 1'b1; if_addr_i = 64'h9000;
      tick();
      check("rstmid_busy", {63'd0, mem_req_o}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_req", {63'd0, mem_req_o}, 64'd0);
      check("rstmid_we", {63'd0, mem_we_o}, 64'd0);
      check("rstmid_addr", mem_addr_o, 64'd0);
      check("rstmid_wdata", mem_wdata_o, 64'd0);
      check("rstmid_wstrb", {56'd0, mem_wstrb_o}, 64'd0);
      check("rstmid_stall", {63'd0, if_stall_o}, 64'd0);
      tick();
      if_req_i = 1'b0; d_req_i = 1'b0;
      rst_n = 1'b1;
      mem_ready_i = 1'b1;
      tick();
      mem_ready_i = 1'b0;
      tick(); tick();
      check("rstmid_no_dready", 64'(dut_d_cnt - base_d), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: the maximum number of consecutive data grants made while a fetch request is pending.
REQ-002 Clock clk, input, 1 bit, rising-edge.
REQ-003 Reset rst_n, input, 1 bit, asynchronous, active-low.
REQ-004 if_req, input, 1: fetch unit requests a 32-bit instruction read.
REQ-005 if_addr, input, 64: fetch byte address, 4-byte aligned.
REQ-006 if_ready, output, 1: one-cycle pulse marking fetch completion.
REQ-007 if_rdata, output, 32: instruction word, valid only when if_ready=1.
REQ-008 d_req, d_we, inputs, 1 each: data access request and write enable.
REQ-009 d_addr, d_wdata, inputs, 64 each; d_wstrb, input, 8: byte enables.
REQ-010 d_ready, output, 1: one-cycle completion pulse; d_rdata, output, 64.
REQ-011 mem_req, mem_we, outputs, 1 each: shared memory request and write enable.
REQ-012 mem_addr, mem_wdata, outputs, 64 each; mem_wstrb, output, 8.
REQ-013 mem_ready, input, 1: memory completion pulse; mem_rdata, input, 64.
REQ-014 if_stall, output, 1: equals if_req & ~if_ready, and drives the fetch-stage stall.

Function
REQ-015 The arbiter SHALL use FSM states IDLE, BUSY_I and BUSY_D.
REQ-016 Requesters SHALL hold req and all payload stable until their ready pulse; the arbiter does not check this.
REQ-017 In IDLE, grant SHALL be decided from the current-cycle requests:
- d_req alone -> BUSY_D.
- if_req alone -> BUSY_I.
- both, with starve_cnt < STARVE_LIMIT -> BUSY_D.
- both, with starve_cnt = STARVE_LIMIT -> BUSY_I.
- neither -> stay in IDLE.
REQ-018 On a grant the arbiter SHALL register the payload; mem_req=1 from the next cycle until the cycle mem_ready=1, inclusive.
REQ-019 For a fetch grant: mem_addr={if_addr[63:3],3'b000}, mem_we=0, mem_wstrb=0, mem_wdata=0.
REQ-020 For a data grant: mem_addr={d_addr[63:3],3'b000}, and mem_we, mem_wdata and mem_wstrb SHALL pass through from the registered data payload.
REQ-021 In BUSY_I with mem_ready=1:
- if_ready=1 in the same cycle (combinational).
- if_rdata = mem_rdata[63:32] when the registered if_addr[2]=1, else mem_rdata[31:0].
- the FSM returns to IDLE.
REQ-022 In BUSY_D with mem_ready=1: d_ready=1 and d_rdata=mem_rdata in the same cycle, and the FSM returns to IDLE.
REQ-023 Minimum latency is 2 cycles from request to ready (grant cycle plus one mem cycle with mem_ready=1); the arbiter sustains at most one transaction per 2 cycles.
REQ-024 starve_cnt is 3 bits and saturating:
- +1 on a data grant while if_req=1.
- cleared on any fetch grant.
- cleared on a data grant while if_req=0.
REQ-025 mem_ready while in IDLE SHALL be ignored: no ready pulse and no state change.
REQ-026 if_ready and d_ready SHALL never be 1 in the same cycle; mem_req SHALL be 0 in IDLE.
REQ-027 If a request drops while BUSY, the transaction SHALL still complete and the ready pulse is still issued.

Reset
REQ-028 While rst_n=0 the arbiter SHALL force:
- FSM to IDLE and starve_cnt to 0.
- mem_req, mem_we, mem_wstrb, mem_addr and mem_wdata to 0.
- if_ready, d_ready and if_stall (the latter gated by if_req) to 0.
- if_rdata and d_rdata to 0.
REQ-029 A reset asserted mid-transaction SHALL abandon it; a mem_ready arriving after reset release is ignored per REQ-025.

Verification
REQ-030 Fetch only: if_addr=0x1004, memory ready after 1 cycle with mem_rdata=0xAAAA_BBBB_CCCC_DDDD -> mem_addr=0x1000, if_rdata=0xAAAABBBB, if_ready pulsed once.
REQ-031 Data write: d_addr=0x2008, d_wdata=0x55, d_wstrb=0x01 -> mem_we=1, mem_addr=0x2008, mem_wstrb=0x01, d_ready pulsed once, if_ready stays 0.
REQ-032 Simultaneous if_req and d_req with starve_cnt=0 -> data granted first, fetch granted next, if_stall=1 until the fetch if_ready.
REQ-033 if_req held high while d_req is continuously re-asserted -> exactly 4 data grants, then a fetch grant, then starve_cnt=0.
REQ-034 rst_n pulled low during BUSY_D while mem_ready stays 0 -> all outputs 0 immediately; after release, a late mem_ready produces no d_ready.
REQ-035 Memory with a 5-cycle wait -> mem_req and mem_addr stable for all 5 cycles, and exactly one ready pulse.
